// File: rtl/rep_add_mult_seq.sv
// Sequential multiplier: builds the 2*WIDTH product by repeated addition (signed or unsigned).
// Latency: done pulses N+1 edges after start, where N is the loaded iteration count (0 allowed).
// Backpressure: none; start is taken only in IDLE, busy marks the window, abort cancels without done.
module rep_add_mult_seq #(
    parameter int WIDTH    = 16,
    parameter bit SWAP_MIN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH-1:0]     mcand_ld, cnt_ld;
    logic                 a_is_mcand;

    // The most-negative input negates to 2^(WIDTH-1), which is still representable unsigned.
    assign mag_a      = (sgn && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign mag_b      = (sgn && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    assign a_is_mcand = !SWAP_MIN || (mag_a >= mag_b);
    assign mcand_ld   = a_is_mcand ? mag_a : mag_b;
    assign cnt_ld     = a_is_mcand ? mag_b : mag_a;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        neg_d     = neg_q;
        product_d = product_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    neg_d   = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                    mcand_d = mcand_ld;
                    cnt_d   = cnt_ld;
                    acc_d   = '0;
                    state_d = (cnt_ld == '0) ? S_FIN : S_CALC;
                end
            end
            S_CALC: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = acc_q + {{WIDTH{1'b0}}, mcand_q};
                    cnt_d = cnt_q - WIDTH'(1);
                    if (cnt_q == WIDTH'(1)) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    product_d = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            mcand_q   <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: doc/rep_add_mult_seq.md
Name: rep_add_mult_seq

Overview:
Self-contained, parametrised sequential multiplier using repeated addition. It is the next generation of the split datapath/controller multiplier: the controller FSM is integrated, the width is generic, and the product is double width. It adds a start/busy/done handshake, an abort input, a signed-operand mode, and an optional smaller-operand-as-counter swap that minimises iteration count. It sits as a slave arithmetic unit beside the sequencing logic that issues operands.

Parameters:
WIDTH, 16, operand width in bits (>=2); product is 2*WIDTH.
SWAP_MIN, 1, 1 = load counter with the smaller operand magnitude and accumulate the larger; 0 = counter always takes |b|, accumulate |a|.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst_n  in  1  reset, asynchronous, active-low.
start  in  1  request; sampled only in IDLE.
abort  in  1  synchronous cancel of a running operation.
sgn  in  1  sampled with start; 1 = a, b are two's complement, 0 = unsigned.
a  in  WIDTH  multiplicand; sampled with start.
b  in  WIDTH  multiplier; sampled with start.
busy  out  1  high while state != IDLE.
done  out  1  registered one-cycle pulse when product is updated.
product  out  2*WIDTH  last completed result; held until next done.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0; done=0; product=0; internal accumulator, counter, multiplicand and sign flag cleared. Deassertion takes effect on the next clk edge. Reset mid-operation discards the operation; no done is issued.
- States: IDLE, CALC, FIN.
- IDLE, start=1 at edge T0:
  - Magnitudes: |x| = x if sgn=0 or MSB=0, else two's-complement negation of x, as a WIDTH-bit unsigned value. The most-negative value maps to 2^(WIDTH-1), which fits.
  - neg_flag = sgn & (a[MSB] ^ b[MSB]).
  - With SWAP_MIN=1: mcand = max(|a|,|b|), cnt = min(|a|,|b|); ties pick |a| as mcand. With SWAP_MIN=0: mcand=|a|, cnt=|b|.
  - acc cleared.
  - Next state: FIN if cnt==0, else CALC.
- CALC, each edge:
  - acc <= acc + zero-extended mcand (2*WIDTH bits; cannot overflow); cnt <= cnt-1.
  - When the pre-decrement cnt==1, next state is FIN.
  - Exactly N additions occur, where N is the loaded cnt.
- FIN, next edge:
  - product <= neg_flag ? -acc : acc (2*WIDTH two's complement; -0 = 0).
  - done <= 1; state <= IDLE.
- done is high for exactly the one cycle after the FIN edge and is 0 at all other times.
- Latency: done rises at edge T0+N+1. Examples: N=0 gives T0+1; N=5 gives T0+6.
- busy is 1 from edge T0 through the FIN edge. It is 0 in the cycle done is high, so a new start may be issued in the done cycle.
- start while busy is ignored; operands are not resampled.
- abort=1 in CALC or FIN returns to IDLE on that edge. product is unchanged and done stays 0.
- abort has priority over the CALC/FIN transitions. abort in IDLE is ignored, and abort=1 with start=1 in IDLE still accepts the start.
- a, b and sgn may change freely after T0 without effect.

Test Plan:
- WIDTH=16, SWAP_MIN=1, unsigned 3 x 5 -> cnt=3; done at T0+4; product=0x0000000F; busy high for 4 cycles.
- Unsigned 0 x 1234 -> FIN directly; done at T0+1; product=0. Repeat with a=1234, b=0 -> same result.
- Signed -3 x 7 (a=0xFFFD, b=0x0007) -> product=0xFFFFFFEB (-21), done at T0+4. Signed -32768 x -1 -> product=0x00008000, done at T0+2.
- SWAP_MIN=1: 1000 x 2 -> done at T0+3, product=2000. SWAP_MIN=0, same operands -> done at T0+3. SWAP_MIN=0 with 2 x 1000 -> done at T0+1001.
- Start pulses during busy and abort at T0+2 of a 10 x 10 operation -> no done pulse, product holds the prior value, busy=0 next cycle; a fresh 4 x 4 then yields 16.
- rst_n low mid-CALC (asynchronous, between edges) -> busy, done and product go 0 immediately; the post-reset operation 7 x 9 = 63 is correct.
